// File: rtl/isp1761_bus_responder_if.sv
// CPU-side parallel bus of the ISP1761-style target: active-low strobes, word address, split data lanes.
// The host bridge drives the master side; the responder sits on the slave side. No flow control beyond the strobes.
interface isp1761_bus_responder_if;
    logic        CS_N;
    logic        WR_N;
    logic        RD_N;
    logic [17:1] A;
    logic [31:0] D_in;
    logic [31:0] D_out;
    logic        D_oe;

    modport master (output CS_N, WR_N, RD_N, A, D_in, input D_out, D_oe);
    modport slave  (input CS_N, WR_N, RD_N, A, D_in, output D_out, D_oe);
endinterface

// File: rtl/isp1761_bus_responder.sv
// Bus target with register map, W1C interrupts and a pop-on-read FIFO; RD_N fall to D_oe is 4 clocks, WR_N rise to update is 3.
// Local pushes are backpressured by push_ready (FIFO full); the host side is paced purely by its strobe timing.
module isp1761_bus_responder #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] CHIP_ID    = 32'h0001_1761
) (
    input  logic                   s_clk,
    input  logic                   s_reset,
    isp1761_bus_responder_if.slave bus,
    output logic                   IRQ,
    input  logic [7:0]             irq_set,
    input  logic                   push_valid,
    input  logic [31:0]            push_data,
    output logic                   push_ready
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [31:0] IRQ_MASK = 32'h8000_00FF;

    localparam logic [17:0] ADR_CHIP_ID    = 18'h00;
    localparam logic [17:0] ADR_SCRATCH    = 18'h04;
    localparam logic [17:0] ADR_IRQ_STATUS = 18'h08;
    localparam logic [17:0] ADR_IRQ_ENABLE = 18'h0C;
    localparam logic [17:0] ADR_FIFO_LEVEL = 18'h10;
    localparam logic [17:0] ADR_DATA_PORT  = 18'h20;

    typedef enum logic [1:0] {IDLE, WR_ACTIVE, RD_ACTIVE} state_t;

    // Two-flop synchronizers; strobes idle high so reset never fakes an access
    logic [2:0]  strb_meta_q, strb_s_q;
    logic [17:1] a_meta_q, a_s_q;
    logic [31:0] d_meta_q, d_s_q;
    logic        cs_s, wr_s, rd_s;

    always_ff @(posedge s_clk or posedge s_reset) begin
        if (s_reset) begin
            strb_meta_q <= 3'b111;
            strb_s_q    <= 3'b111;
            a_meta_q    <= '0;
            a_s_q       <= '0;
            d_meta_q    <= '0;
            d_s_q       <= '0;
        end else begin
            strb_meta_q <= {bus.CS_N, bus.WR_N, bus.RD_N};
            strb_s_q    <= strb_meta_q;
            a_meta_q    <= bus.A;
            a_s_q       <= a_meta_q;
            d_meta_q    <= bus.D_in;
            d_s_q       <= d_meta_q;
        end
    end

    assign {cs_s, wr_s, rd_s} = strb_s_q;

    state_t      state_q;
    logic        rd_first_q;
    logic [17:1] wr_addr_q;
    logic [31:0] wr_data_q;
    logic [31:0] dout_q;
    logic        doe_q;

    logic [31:0] scratch_q, scratch_d;
    logic [31:0] irq_enable_q, irq_enable_d;
    logic [31:0] irq_status_q, irq_status_d;
    logic        irq_q, irq_d;

    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic        wr_commit, rd_load, pop_req, push_ok, pop_ok, fifo_empty, underflow;
    logic [17:0] rd_byte, wr_byte;
    logic [31:0] rdata, status_clr;

    assign rd_byte    = {a_s_q, 1'b0};
    assign wr_byte    = {wr_addr_q, 1'b0};
    assign fifo_empty = (count_q == '0);
    assign push_ready = (count_q != FULL_CNT);
    assign push_ok    = push_valid & push_ready;

    // Commit fires once, on the cycle the synchronized write strobe or select releases
    assign wr_commit = (state_q == WR_ACTIVE) && (wr_s || cs_s);
    assign rd_load   = (state_q == RD_ACTIVE) && rd_first_q && !(rd_s || cs_s);
    assign pop_req   = rd_load && (rd_byte == ADR_DATA_PORT);
    assign pop_ok    = pop_req && !fifo_empty;
    assign underflow = pop_req && fifo_empty;

    always_comb begin
        rdata = 32'h0;
        case (rd_byte)
            ADR_CHIP_ID:    rdata = CHIP_ID;
            ADR_SCRATCH:    rdata = scratch_q;
            ADR_IRQ_STATUS: rdata = irq_status_q;
            ADR_IRQ_ENABLE: rdata = irq_enable_q;
            ADR_FIFO_LEVEL: rdata = 32'(count_q);
            ADR_DATA_PORT:  rdata = fifo_empty ? 32'h0 : mem_q[rd_ptr_q];
            default:        rdata = 32'h0;
        endcase
    end

    always_ff @(posedge s_clk or posedge s_reset) begin
        if (s_reset) begin
            state_q    <= IDLE;
            rd_first_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            dout_q     <= '0;
            doe_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Both strobes low together is a protocol error and is ignored
                    if (!cs_s && !wr_s && rd_s) begin
                        state_q   <= WR_ACTIVE;
                        wr_addr_q <= a_s_q;
                        wr_data_q <= d_s_q;
                    end else if (!cs_s && !rd_s && wr_s) begin
                        state_q    <= RD_ACTIVE;
                        rd_first_q <= 1'b1;
                    end
                end
                WR_ACTIVE: begin
                    if (wr_s || cs_s) begin
                        state_q <= IDLE;
                    end else begin
                        wr_addr_q <= a_s_q;
                        wr_data_q <= d_s_q;
                    end
                end
                RD_ACTIVE: begin
                    if (rd_s || cs_s) begin
                        state_q    <= IDLE;
                        doe_q      <= 1'b0;
                        rd_first_q <= 1'b0;
                    end else if (rd_first_q) begin
                        dout_q     <= rdata;
                        doe_q      <= 1'b1;
                        rd_first_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        scratch_d    = scratch_q;
        irq_enable_d = irq_enable_q;
        status_clr   = 32'h0;
        if (wr_commit) begin
            case (wr_byte)
                ADR_SCRATCH:    scratch_d    = wr_data_q;
                ADR_IRQ_ENABLE: irq_enable_d = wr_data_q & IRQ_MASK;
                ADR_IRQ_STATUS: status_clr   = wr_data_q & IRQ_MASK;
                default:        ;
            endcase
        end
        // Set is ORed after the clear so a coincident source pulse wins
        irq_status_d = (irq_status_q & ~status_clr) | {underflow, 23'h0, irq_set};
        irq_d        = |(irq_status_q & irq_enable_q);

        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge s_clk or posedge s_reset) begin
        if (s_reset) begin
            scratch_q    <= '0;
            irq_enable_q <= '0;
            irq_status_q <= '0;
            irq_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            scratch_q    <= scratch_d;
            irq_enable_q <= irq_enable_d;
            irq_status_q <= irq_status_d;
            irq_q        <= irq_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge s_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign bus.D_out = dout_q;
    assign bus.D_oe  = doe_q;
    assign IRQ       = irq_q;
endmodule
